// File: rtl/uart_inst_loader.sv
// Boot loader: receives a program over UART 8N1, packs bytes little-endian into 32-bit words
// and replays each word LSB first on the bit_out/bitRdy pair, sequencing Upload and cpu_reset.
module uart_inst_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        bit_out,
    output logic        bitRdy,
    output logic        Upload,
    output logic        cpu_reset,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun,
    output logic [10:0] word_count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [10:0]   WORD_LIMIT = 11'(MAX_WORDS);
    localparam logic [31:0]   TERMINATOR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {LOAD_RST, LOAD, FINISH, RUN} seq_state_t;
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} rx_state_t;

    seq_state_t  seq_q, seq_d;
    rx_state_t   rx_st_q, rx_st_d;
    logic          rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic          upload_q, upload_d, cpu_reset_q, cpu_reset_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   word_lo_q, word_lo_d;
    logic [31:0]   shift_q, shift_d;
    logic [4:0]    shift_cnt_q, shift_cnt_d;
    logic          phase_b_q, phase_b_d, bit_q, bit_d, bit_rdy_q, bit_rdy_d;
    logic          busy_q, busy_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [10:0]   word_count_q, word_count_d;
    logic          term_seen_q, term_seen_d;
    logic          loading, word_done, term_now;
    logic [31:0]   full_word;

    always_comb begin
        seq_d        = seq_q;
        rx_st_d      = rx_st_q;
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        rst_cnt_d    = rst_cnt_q;
        upload_d     = upload_q;
        cpu_reset_d  = cpu_reset_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        byte_idx_d   = byte_idx_q;
        word_lo_d    = word_lo_q;
        shift_d      = shift_q;
        shift_cnt_d  = shift_cnt_q;
        phase_b_d    = phase_b_q;
        bit_d        = bit_q;
        bit_rdy_d    = bit_rdy_q;
        busy_d       = busy_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        word_count_d = word_count_q;
        term_seen_d  = term_seen_q;
        loading      = (seq_q == LOAD);
        word_done    = 1'b0;
        full_word    = {rx_byte_q, word_lo_q};

        if (loading && byte_valid_q) begin
            case (byte_idx_q)
                2'd0:    word_lo_d[7:0]   = rx_byte_q;
                2'd1:    word_lo_d[15:8]  = rx_byte_q;
                2'd2:    word_lo_d[23:16] = rx_byte_q;
                default: word_done        = 1'b1;
            endcase
            byte_idx_d = byte_idx_q + 1'b1;
        end
        term_now = word_done && (full_word == TERMINATOR);

        // A bad stop bit drops the byte and realigns the word to the next good byte.
        if (!loading) begin
            rx_st_d = U_IDLE;
        end else begin
            case (rx_st_q)
                U_IDLE: begin
                    if (!rx_s_q) begin
                        rx_st_d    = U_START;
                        baud_cnt_d = '0;
                    end
                end
                U_START: begin
                    if (baud_cnt_q == HALF_LAST) begin
                        baud_cnt_d = '0;
                        bit_idx_d  = '0;
                        rx_st_d    = rx_s_q ? U_IDLE : U_DATA;
                    end else begin
                        baud_cnt_d = baud_cnt_q + 1'b1;
                    end
                end
                U_DATA: begin
                    if (baud_cnt_q == FULL_LAST) begin
                        baud_cnt_d = '0;
                        rx_byte_d  = {rx_s_q, rx_byte_q[7:1]};
                        if (bit_idx_q == 3'd7) rx_st_d = U_STOP;
                        else                   bit_idx_d = bit_idx_q + 1'b1;
                    end else begin
                        baud_cnt_d = baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (baud_cnt_q == FULL_LAST) begin
                        baud_cnt_d = '0;
                        rx_st_d    = U_IDLE;
                        if (rx_s_q) begin
                            byte_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            byte_idx_d  = '0;
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + 1'b1;
                    end
                end
            endcase
        end

        if (busy_q) begin
            if (!phase_b_q) begin
                bit_rdy_d = 1'b1;
                phase_b_d = 1'b1;
            end else begin
                bit_rdy_d = 1'b0;
                phase_b_d = 1'b0;
                if (shift_cnt_q == 5'd31) begin
                    busy_d       = 1'b0;
                    word_count_d = word_count_q + 1'b1;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    shift_d     = shift_q >> 1;
                    bit_d       = shift_q[1];
                end
            end
        end

        if (term_now) begin
            term_seen_d = 1'b1;
        end else if (word_done) begin
            if (busy_q) begin
                overrun_d = 1'b1;
            end else begin
                shift_d     = full_word;
                bit_d       = full_word[0];
                busy_d      = 1'b1;
                shift_cnt_d = '0;
                phase_b_d   = 1'b0;
                bit_rdy_d   = 1'b0;
            end
        end

        // Upload drops on the same clock that the end-of-load cpu_reset pulse starts.
        case (seq_q)
            LOAD_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    seq_d       = LOAD;
                    cpu_reset_d = 1'b0;
                    rst_cnt_d   = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (!busy_q && (term_seen_q || term_now || word_count_q >= WORD_LIMIT)) begin
                    seq_d       = FINISH;
                    upload_d    = 1'b0;
                    cpu_reset_d = 1'b1;
                    rst_cnt_d   = '0;
                end
            end
            FINISH: begin
                if (rst_cnt_q == RST_LAST) begin
                    seq_d       = RUN;
                    cpu_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            default: seq_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            seq_q        <= LOAD_RST;
            rx_st_q      <= U_IDLE;
            rst_cnt_q    <= '0;
            upload_q     <= 1'b1;
            cpu_reset_q  <= 1'b1;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            byte_idx_q   <= '0;
            word_lo_q    <= '0;
            shift_q      <= '0;
            shift_cnt_q  <= '0;
            phase_b_q    <= 1'b0;
            bit_q        <= 1'b0;
            bit_rdy_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            word_count_q <= '0;
            term_seen_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            seq_q        <= seq_d;
            rx_st_q      <= rx_st_d;
            rst_cnt_q    <= rst_cnt_d;
            upload_q     <= upload_d;
            cpu_reset_q  <= cpu_reset_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            byte_idx_q   <= byte_idx_d;
            word_lo_q    <= word_lo_d;
            shift_q      <= shift_d;
            shift_cnt_q  <= shift_cnt_d;
            phase_b_q    <= phase_b_d;
            bit_q        <= bit_d;
            bit_rdy_q    <= bit_rdy_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            word_count_q <= word_count_d;
            term_seen_q  <= term_seen_d;
        end
    end

    assign bit_out    = bit_q;
    assign bitRdy     = bit_rdy_q;
    assign Upload     = upload_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign word_count = word_count_q;
endmodule
